// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the DataPath strobes for
// register-to-register ALU instructions, MUL/DIV and HALT.
module control_sequencer #(
    parameter int OPC_W = 5,
    parameter int NREG  = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    output logic             pc_out,
    output logic             mdr_out,
    output logic             zhigh_out,
    output logic             zlow_out,
    output logic             mar_in,
    output logic             pc_in,
    output logic             mdr_in,
    output logic             ir_in,
    output logic             y_in,
    output logic             hi_in,
    output logic             lo_in,
    output logic             zhigh_in,
    output logic             zlow_in,
    output logic             inc_pc,
    output logic             read,
    output logic [OPC_W-1:0] alu_op,
    output logic [NREG-1:0]  r_in,
    output logic [NREG-1:0]  r_out,
    output logic             running,
    output logic             illegal
);

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, E3, E4, E5, E6, HALTED
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5'b01111);
    localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5'b10000);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

    state_t state_q, state_d;

    logic [OPC_W-1:0] opcode;
    logic [3:0]       ra, rb, rc;
    logic [NREG-1:0]  ra_hot, rb_hot, rc_hot;
    logic             is_alu, is_muldiv, is_halt;
    logic             unused_ir;

    assign opcode    = ir[31 -: OPC_W];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign ra_hot = {{(NREG-1){1'b0}}, 1'b1} << ra;
    assign rb_hot = {{(NREG-1){1'b0}}, 1'b1} << rb;
    assign rc_hot = {{(NREG-1){1'b0}}, 1'b1} << rc;

    always_comb begin
        is_alu = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: is_alu = 1'b1;
            default:                                       is_alu = 1'b0;
        endcase
    end

    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_halt   = (opcode == OP_HALT);

    // Only IDLE and HALTED react to start; every other state advances unconditionally.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = F0;
            F0:      state_d = F1;
            F1:      state_d = F2;
            F2:      state_d = E3;
            E3: begin
                if (is_halt)                     state_d = HALTED;
                else if (is_alu || is_muldiv)    state_d = E4;
                else                             state_d = F0;
            end
            E4:      state_d = E5;
            E5:      state_d = is_muldiv ? E6 : F0;
            E6:      state_d = F0;
            HALTED:  if (start) state_d = F0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Moore decode from the state register; ir supplies operands from E3 onward.
    always_comb begin
        pc_out    = 1'b0;
        mdr_out   = 1'b0;
        zhigh_out = 1'b0;
        zlow_out  = 1'b0;
        mar_in    = 1'b0;
        pc_in     = 1'b0;
        mdr_in    = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        zhigh_in  = 1'b0;
        zlow_in   = 1'b0;
        inc_pc    = 1'b0;
        read      = 1'b0;
        alu_op    = '0;
        r_in      = '0;
        r_out     = '0;
        illegal   = 1'b0;
        running   = 1'b0;
        unique case (state_q)
            F0: begin
                running = 1'b1;
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                zlow_in = 1'b1;
            end
            F1: begin
                running  = 1'b1;
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            F2: begin
                running = 1'b1;
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            E3: begin
                running = 1'b1;
                if (is_alu || is_muldiv) begin
                    r_out = rb_hot;
                    y_in  = 1'b1;
                end else if (!is_halt) begin
                    illegal = 1'b1;
                end
            end
            E4: begin
                running  = 1'b1;
                r_out    = rc_hot;
                alu_op   = opcode;
                zlow_in  = 1'b1;
                zhigh_in = is_muldiv;
            end
            E5: begin
                running  = 1'b1;
                zlow_out = 1'b1;
                if (is_muldiv) lo_in = 1'b1;
                else           r_in  = ra_hot;
            end
            E6: begin
                running   = 1'b1;
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
